// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - register/stage indices into the 5-bit pause/flush vectors
//   - FSM state encoding (2 bits)
//   - stall_mask(): builds the pause/flush pair for a stall raised at stage k
package pipe_pkg;

  localparam int NUM_REGS = 5;

  localparam int PS_PC    = 0;
  localparam int PS_IFID  = 1;
  localparam int PS_IDEX  = 2;
  localparam int PS_EXMEM = 3;
  localparam int PS_MEMWB = 4;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_DIV      = 2'd1;
  localparam logic [1:0] ST_DIV_DONE = 2'd2;
  localparam logic [1:0] ST_MEMWAIT  = 2'd3;

  // A taken branch squashes the two wrong-path instructions behind it.
  localparam logic [NUM_REGS-1:0] BR_FLUSH = 5'b00110;

  typedef struct packed {
    logic [NUM_REGS-1:0] pause;
    logic [NUM_REGS-1:0] flush;
  } mask_t;

  // Stall at stage k: hold registers 0..k, inject a bubble into k+1.
  function automatic mask_t stall_mask(input int k);
    mask_t m;
    for (int i = 0; i < NUM_REGS; i++) begin
      m.pause[i] = (i <= k);
      m.flush[i] = (i == k + 1);
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard handshake bundle between the pipeline (master) and pipe_ctrl (slave).
//   inputs to the controller : if_ack, id_load_use, ex_div_start,
//                              ex_branch_taken, mem_req, mem_ack, trap
//   outputs of the controller: pause[4:0], flush[4:0], div_busy, bus_err
interface pipe_ctrl_if;
  logic                           if_ack;
  logic                           id_load_use;
  logic                           ex_div_start;
  logic                           ex_branch_taken;
  logic                           mem_req;
  logic                           mem_ack;
  logic                           trap;
  logic [pipe_pkg::NUM_REGS-1:0]  pause;
  logic [pipe_pkg::NUM_REGS-1:0]  flush;
  logic                           div_busy;
  logic                           bus_err;

  modport master (
    output if_ack, id_load_use, ex_div_start, ex_branch_taken, mem_req, mem_ack, trap,
    input  pause, flush, div_busy, bus_err
  );

  modport slave (
    input  if_ack, id_load_use, ex_div_start, ex_branch_taken, mem_req, mem_ack, trap,
    output pause, flush, div_busy, bus_err
  );
endinterface

// File: rtl/stall_cnt.sv
// Loadable up/down counter with zero flag.
//   clk, rst      : clock, async active-high reset (count -> 0)
//   load/load_val : synchronous load, highest priority
//   inc / dec     : count up / down (inc wins if both)
//   cnt, zero     : current count and (cnt == 0)
module stall_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt + 1'b1;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for the five-stage core.
//   clk, rst : clock, async active-high reset
//   bus      : pipe_ctrl_if.slave -- hazard inputs in, pause/flush/div_busy/bus_err out
// Holds the divide sequencer and the data-bus timeout; everything else is
// combinational from the hazard inputs and that state.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int DIV_LATENCY = 33,
  parameter int BUS_TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  logic [1:0] state, state_nx;
  logic       div_pend, div_pend_nx;   // MEMWAIT was entered with a divide in flight
  logic       div_exp, div_exp_nx;     // ...and that divide has since run out
  logic [7:0] div_cnt, to_cnt, div_ld_val;
  logic       div_zero, to_zero;
  logic       div_ld, div_dec, to_ld, to_inc;
  logic       bus_raw, timeout, div_run, div_expire;
  logic       wait_m, div_m, br_m, lu_m, ifw_m;
  logic [NUM_REGS-1:0] p, f;
  mask_t      mk;

  stall_cnt #(.W(8)) u_div_cnt (
    .clk(clk), .rst(rst), .load(div_ld), .load_val(div_ld_val),
    .inc(1'b0), .dec(div_dec), .cnt(div_cnt), .zero(div_zero)
  );

  stall_cnt #(.W(8)) u_to_cnt (
    .clk(clk), .rst(rst), .load(to_ld), .load_val(8'd0),
    .inc(to_inc), .dec(1'b0), .cnt(to_cnt), .zero(to_zero)
  );

  assign bus_raw = bus.mem_req && !bus.mem_ack;
  // The zero check keeps an out-of-range timeout of 0 from firing on MEMWAIT entry.
  assign timeout = (state == ST_MEMWAIT) && !bus.mem_ack && !to_zero &&
                   (to_cnt == 8'(BUS_TIMEOUT));
  // Cycles in which the divider is still occupying EX and counting.
  assign div_run    = (state == ST_DIV) || ((state == ST_MEMWAIT) && div_pend && !div_exp);
  assign div_expire = div_run && div_zero;

  always_comb begin
    wait_m = (state == ST_MEMWAIT) ? (!bus.mem_ack && !timeout) : bus_raw;
    div_m  = div_run || ((state == ST_RUN) && bus.ex_div_start);
    // A branch under a bus/divide stall stays in EX and is acted on after release.
    br_m   = bus.ex_branch_taken && !wait_m && !div_m;
    lu_m   = bus.id_load_use && !bus.ex_branch_taken;
    ifw_m  = !bus.if_ack && !bus.ex_branch_taken;
  end

  always_comb begin
    p  = '0;
    f  = '0;
    mk = stall_mask(PS_EXMEM);
    if (wait_m) begin p = p | mk.pause; f = f | mk.flush; end
    mk = stall_mask(PS_IDEX);
    if (div_m)  begin p = p | mk.pause; f = f | mk.flush; end
    mk = stall_mask(PS_IFID);
    if (lu_m)   begin p = p | mk.pause; f = f | mk.flush; end
    mk = stall_mask(PS_PC);
    if (ifw_m)  begin p = p | mk.pause; f = f | mk.flush; end
    if (br_m)   f = f | BR_FLUSH;

    bus.pause    = p;
    bus.flush    = f & ~p;
    bus.div_busy = div_m;
    bus.bus_err  = timeout;
    if (rst) begin
      bus.pause    = '0;
      bus.flush    = '1;
      bus.div_busy = 1'b0;
      bus.bus_err  = 1'b0;
    end else if (bus.trap) begin
      bus.pause    = '0;
      bus.flush    = 5'b11110;
      bus.div_busy = 1'b0;
      bus.bus_err  = 1'b0;
    end
  end

  always_comb begin
    state_nx    = state;
    div_pend_nx = div_pend;
    div_exp_nx  = div_exp;
    div_ld      = 1'b0;
    div_ld_val  = '0;
    div_dec     = 1'b0;
    to_ld       = 1'b0;
    to_inc      = 1'b0;
    if (bus.trap) begin
      state_nx    = ST_RUN;
      div_pend_nx = 1'b0;
      div_exp_nx  = 1'b0;
      div_ld      = 1'b1;
      to_ld       = 1'b1;
    end else begin
      div_dec = div_run && !div_zero;
      case (state)
        ST_RUN: begin
          div_pend_nx = 1'b0;
          div_exp_nx  = 1'b0;
          if (bus_raw) begin
            state_nx = ST_MEMWAIT;
            to_ld    = 1'b1;
          end else if (bus.ex_div_start) begin
            state_nx   = ST_DIV;
            div_ld     = 1'b1;
            div_ld_val = 8'(DIV_LATENCY - 2);
          end
        end
        ST_DIV: begin
          div_pend_nx = bus_raw;
          div_exp_nx  = bus_raw && div_zero;
          if (bus_raw) begin
            state_nx = ST_MEMWAIT;
            to_ld    = 1'b1;
          end else if (div_zero) begin
            state_nx = ST_DIV_DONE;
          end
        end
        ST_DIV_DONE: state_nx = ST_RUN;
        default: begin
          if (bus.mem_ack) begin
            // Resume the divide where it stands; an expired one still needs its capture cycle.
            if (!div_pend)                state_nx = ST_RUN;
            else if (div_exp || div_expire) state_nx = ST_DIV_DONE;
            else                          state_nx = ST_DIV;
            div_pend_nx = 1'b0;
            div_exp_nx  = 1'b0;
          end else if (timeout) begin
            state_nx    = ST_RUN;
            div_pend_nx = 1'b0;
            div_exp_nx  = 1'b0;
          end else begin
            div_exp_nx = div_exp || div_expire;
            to_inc     = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      div_pend <= 1'b0;
      div_exp  <= 1'b0;
    end else begin
      state    <= state_nx;
      div_pend <= div_pend_nx;
      div_exp  <= div_exp_nx;
    end
  end
endmodule
